// File: rtl/pcie_pipe_pkg.sv
// Shared PIPE receive definitions.
// COM symbol, deskew states and lane slicing helpers.
package pcie_pipe_pkg;

  localparam logic [7:0] COM_SYMBOL = 8'hBC;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_SEARCH,
    DS_ALIGNED
  } deskewState_t;

  function automatic int laneLsb(
    input int lane,
    input int width
  );
    return lane * width;
  endfunction

  function automatic int busWidth(
    input int lanes,
    input int width
  );
    return lanes * width;
  endfunction

endpackage

// File: rtl/lane_fifo.sv
// Per-lane synchronous FIFO with flush.
// Head entry is visible combinationally.
module lane_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             wrEn,
  input  logic             rdEn,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             doWr;
  logic             doRd;

  assign empty = wrPtr == rdPtr;
  assign full  = (wrPtr[AW] != rdPtr[AW]) &&
                 (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doRd  = rdEn && !empty;
  // A read in the same cycle frees the slot a full FIFO writes into.
  assign doWr  = wrEn && (!full || doRd);
  assign head  = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doWr) wrPtr <= wrPtr + (AW+1)'(1);
      if (doRd) rdPtr <= rdPtr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (doWr && !flush) mem[wrPtr[AW-1:0]] <= wrData;
  end

endmodule

// File: rtl/rx_lane_deskew.sv
// Multi-lane Rx deskew: aligns active lanes on a common COM
// and emits one lane-aligned symbol vector per cycle.
module rx_lane_deskew
  import pcie_pipe_pkg::*;
#(
  parameter int         LANESNUMBER = 16,
  parameter int         PIPEWIDTH   = 8,
  parameter int         DEPTH       = 8,
  parameter logic [7:0] COM         = COM_SYMBOL
) (
  input  logic                             CLK,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [LANESNUMBER-1:0]           activeLanes,
  input  logic [PIPEWIDTH*LANESNUMBER-1:0] RxData,
  input  logic [LANESNUMBER-1:0]           RxDataK,
  input  logic [LANESNUMBER-1:0]           RxValid,
  output logic [PIPEWIDTH*LANESNUMBER-1:0] DeskewData,
  output logic [LANESNUMBER-1:0]           DeskewDataK,
  output logic                             DeskewValid,
  output logic                             aligned,
  output logic                             skewError,
  output logic [$clog2(DEPTH)-1:0]         maxSkew
);

  localparam int SW = $clog2(DEPTH);
  localparam int FW = PIPEWIDTH + 1;
  localparam int BW = busWidth(LANESNUMBER, PIPEWIDTH);
  localparam logic [PIPEWIDTH-1:0] COMW = PIPEWIDTH'(COM);

  deskewState_t state;
  deskewState_t nextState;

  logic [LANESNUMBER-1:0] act;
  logic [LANESNUMBER-1:0] started;
  logic [LANESNUMBER-1:0] isCom;
  logic [LANESNUMBER-1:0] wrEn;
  logic [LANESNUMBER-1:0] rdEn;
  logic [LANESNUMBER-1:0] full;
  logic [LANESNUMBER-1:0] empty;
  logic [LANESNUMBER-1:0] headCom;
  logic [LANESNUMBER-1:0] ovfLane;
  logic [LANESNUMBER-1:0] headK;
  logic [BW-1:0]          headData;
  logic [SW-1:0]          skewCnt;

  logic running;
  logic anyStarted;
  logic allStarted;
  logic allNonEmpty;
  logic allHeadCom;
  logic anyHeadCom;
  logic lockNow;
  logic rdAll;
  logic misalign;
  logic err;
  logic flush;

  for (genvar i = 0; i < LANESNUMBER; i++) begin : gLane
    logic [PIPEWIDTH-1:0] sym;
    logic [FW-1:0]        headW;

    assign sym = RxData[laneLsb(i, PIPEWIDTH) +: PIPEWIDTH];
    assign isCom[i] = RxValid[i] && RxDataK[i] && (sym == COMW);
    // Before its COM a lane discards; afterwards it keeps every valid symbol.
    assign wrEn[i] = running && act[i] &&
                     (started[i] ? RxValid[i] : isCom[i]);
    assign rdEn[i] = rdAll && act[i];
    assign headCom[i] = !empty[i] && headW[PIPEWIDTH] &&
                        (headW[PIPEWIDTH-1:0] == COMW);
    assign ovfLane[i] = wrEn[i] && full[i] && !rdEn[i];
    assign headData[laneLsb(i, PIPEWIDTH) +: PIPEWIDTH] =
      act[i] ? headW[PIPEWIDTH-1:0] : '0;
    assign headK[i] = act[i] && headW[PIPEWIDTH];

    lane_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
    ) uFifo (
      .clk    (CLK),
      .reset  (reset),
      .flush  (flush),
      .wrEn   (wrEn[i]),
      .rdEn   (rdEn[i]),
      .wrData ({RxDataK[i], sym}),
      .head   (headW),
      .full   (full[i]),
      .empty  (empty[i])
    );
  end

  assign running     = enable && (state != DS_IDLE);
  assign anyStarted  = |(started & act);
  assign allStarted  = &(started | ~act);
  assign allNonEmpty = (|act) && (&(~empty | ~act));
  assign allHeadCom  = (|act) && (&(headCom | ~act));
  assign anyHeadCom  = |(headCom & act);
  assign lockNow     = (state == DS_SEARCH) && allHeadCom;
  assign rdAll       = lockNow ||
                       ((state == DS_ALIGNED) && allNonEmpty);
  assign misalign    = (state == DS_ALIGNED) && allNonEmpty &&
                       anyHeadCom && !allHeadCom;
  assign err         = running && ((|ovfLane) || misalign);
  assign flush       = !enable || err || (state == DS_IDLE);

  always_ff @(posedge CLK) begin
    if (reset) state <= DS_IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      DS_IDLE:    if (enable) nextState = DS_SEARCH;
      DS_SEARCH:  if (lockNow && !err) nextState = DS_ALIGNED;
      DS_ALIGNED: if (err) nextState = DS_SEARCH;
      default:    nextState = DS_IDLE;
    endcase
    if (!enable) nextState = DS_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      act     <= '0;
      started <= '0;
      skewCnt <= '0;
    end else begin
      if ((state == DS_IDLE) && enable) act <= activeLanes;
      if (flush) begin
        started <= '0;
        skewCnt <= '0;
      end else begin
        started <= started | wrEn;
        // Runs from the first lane's COM until the last lane's COM.
        if (!anyStarted)
          skewCnt <= '0;
        else if (!allStarted && (skewCnt != '1))
          skewCnt <= skewCnt + SW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset || !enable) begin
      DeskewData  <= '0;
      DeskewDataK <= '0;
      DeskewValid <= 1'b0;
      aligned     <= 1'b0;
      skewError   <= 1'b0;
      maxSkew     <= '0;
    end else begin
      skewError   <= err;
      DeskewValid <= rdAll && !err;
      DeskewData  <= (rdAll && !err) ? headData : '0;
      DeskewDataK <= (rdAll && !err) ? headK : '0;
      aligned     <= nextState == DS_ALIGNED;
      if (state == DS_IDLE)
        maxSkew <= '0;
      else if (lockNow && !err)
        maxSkew <= skewCnt;
    end
  end

endmodule
